aes_axis_block_packer: RTL and testbench
========================================

Name: aes_axis_block_packer

Overview:
Upstream stage of the AES-128 CTR core. Accepts a 32-bit AXI-Stream (tdata/tkeep/tlast) and assembles 128-bit blocks with a 16-bit byte keep and a last flag. Presents each block on a valid/ready block interface that connects directly to the CTR core's in_valid/in_ready/in_data/in_keep/in_last. Double-buffered (assembly register plus output register) so the stream runs at one beat per cycle while the core is draining.

Parameters:
CNT_W, 32, width of the blocks_out and packets_out status counters (wrap modulo 2^CNT_W)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
flush  in  1  synchronous clear: drop partial block and output block, zero counters
s_tvalid  in  1  stream beat valid
s_tready  out  1  stream beat ready
s_tdata  in  32  stream data
s_tkeep  in  4  stream byte enables
s_tlast  in  1  end of packet
out_valid  out  1  block valid (to CTR in_valid)
out_ready  in  1  block ready (from CTR in_ready)
out_data  out  128  block data
out_keep  out  16  block byte keep
out_last  out  1  last block of packet
blocks_out  out  CNT_W  blocks handed off (out_valid && out_ready)
packets_out  out  CNT_W  blocks handed off with out_last=1
busy  out  1  partial assembly or output block pending

Behaviour:
- Reset (async, rst_n=0): s_tready=0 for the reset cycle, then 1; out_valid=0, out_data=0, out_keep=0, out_last=0, counters=0, busy=0, word count=0, state FILL.
- Lane mapping: k-th accepted beat of a block (k=0..3) goes to out_data[32k+31:32k], its tkeep to out_keep[4k+3:4k]. Unfilled lanes: data 0, keep 0.
- Beat accepted when s_tvalid && s_tready.
- Null beat (tkeep=0, tlast=0): accepted and discarded; word count unchanged.
- Block completes on an accepted beat when the word count reaches 4 or s_tlast=1. Beat with tkeep=0 and tlast=1: closes the current block. If no words are gathered yet, it emits a block with keep=0, last=1 so the packet boundary is preserved.
- States:
  - FILL: s_tready=1. On a completing beat, if the output slot is empty or drains this cycle (out_valid && out_ready), load the output register directly: out_valid=1 next cycle, latency 1 cycle. Assembly then clears and the block stays in FILL. Otherwise latch the completed block in the assembly register and go to HOLD.
  - HOLD: s_tready=0. When the output slot is empty or draining, move assembly to output and return to FILL.
- Output register holds data/keep/last stable while out_valid && !out_ready; out_valid drops the cycle after a handshake unless refilled the same cycle (back-to-back blocks allowed).
- flush: priority over everything. s_tready=0 in the flush cycle; next cycle out_valid=0, assembly empty, counters 0, state FILL. A beat presented during flush is not accepted.
- busy = (word count≠0) || HOLD || out_valid.
- Counters increment on the output handshake only and wrap silently.

Optional Feature:
AES_PACKER_KEEPCHK_EN: when defined, adds output keep_err (1 bit, reset 0). It is a sticky flag set on an accepted beat whose tkeep is non-contiguous (not of form 0..01..1 from bit 0), or whose tkeep≠4'hF without tlast=1. Cleared only by flush or reset. Data path is unaffected. When undefined, the port and logic are absent.

Test Plan:
- 4 beats 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, keep=F, last on beat 4, out_ready=1 -> one block 0x0F0E..0100, keep=FFFF, last=1, out_valid one cycle after beat 4; blocks_out=1, packets_out=1.
- 6 beats, keep=F, last on beat 6 -> block1 keep=FFFF last=0; block2 keep=00FF last=1, lanes 2-3 data=0; packets_out=1.
- out_ready=0 while streaming 8 beats -> first block held stable, second block fills, then s_tready=0 (HOLD). Raise out_ready -> both blocks delivered in order, no beat lost.
- Empty assembly, beat keep=0 last=1 -> block keep=0000 last=1 data=0; null beat keep=0 last=0 -> no block, count unchanged.
- 2 beats accepted then flush -> no block emitted, counters 0; next 4-beat packet emitted as a clean block in lanes 0-3.
- rst_n asserted with out_valid=1 and 3 words gathered -> out_valid=0 immediately, all outputs reset; after release a fresh packet packs from lane 0.

Source files
------------

// File: rtl/aes_axis_block_packer.sv
// Packs a 32-bit AXI-Stream into 128-bit blocks for the AES-128 CTR core (assembly + output double buffer).
// Optional sticky tkeep checker enabled with `define AES_PACKER_KEEPCHK_EN (adds output keep_err).
module aes_axis_block_packer #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             s_tvalid,
  output logic             s_tready,
  input  logic [31:0]      s_tdata,
  input  logic [3:0]       s_tkeep,
  input  logic             s_tlast,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [15:0]      out_keep,
  output logic             out_last,
  output logic [CNT_W-1:0] blocks_out,
  output logic [CNT_W-1:0] packets_out,
`ifdef AES_PACKER_KEEPCHK_EN
  output logic             keep_err,
`endif
  output logic             busy
);

  typedef enum logic {FILL, HOLD} state_e;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_e           state_q, state_d;
  logic             alive_q;
  logic [127:0]     asm_data_q, asm_data_d;
  logic [15:0]      asm_keep_q, asm_keep_d;
  logic             asm_last_q, asm_last_d;
  logic [2:0]       wcnt_q, wcnt_d;
  logic             ov_q, ov_d;
  logic [127:0]     od_q, od_d;
  logic [15:0]      ok_q, ok_d;
  logic             ol_q, ol_d;
  logic [CNT_W-1:0] blocks_q, blocks_d;
  logic [CNT_W-1:0] packets_q, packets_d;

  logic             accept, beat_null, has_word, slot_free, handshake, complete;
  logic [127:0]     merged_data;
  logic [15:0]      merged_keep;
  logic [2:0]       merged_cnt;

  assign s_tready = alive_q && (state_q == FILL) && !flush;

  always_comb begin
    state_d    = state_q;
    asm_data_d = asm_data_q;
    asm_keep_d = asm_keep_q;
    asm_last_d = asm_last_q;
    wcnt_d     = wcnt_q;
    ov_d       = ov_q;
    od_d       = od_q;
    ok_d       = ok_q;
    ol_d       = ol_q;
    blocks_d   = blocks_q;
    packets_d  = packets_q;

    accept    = s_tvalid && s_tready;
    beat_null = (s_tkeep == 4'h0) && !s_tlast;
    has_word  = (s_tkeep != 4'h0);
    slot_free = !ov_q || out_ready;
    handshake = ov_q && out_ready;

    // A keep=0 beat carrying tlast only closes the block; it never occupies a lane.
    merged_data = asm_data_q;
    merged_keep = asm_keep_q;
    if (has_word) begin
      merged_data[{wcnt_q[1:0], 5'b00000} +: 32] = s_tdata;
      merged_keep[{wcnt_q[1:0], 2'b00} +: 4]     = s_tkeep;
    end
    merged_cnt = wcnt_q + {2'b00, has_word};
    complete   = (merged_cnt == 3'd4) || s_tlast;

    if (handshake) begin
      ov_d     = 1'b0;
      blocks_d = blocks_q + CNT_ONE;
      if (ol_q) packets_d = packets_q + CNT_ONE;
    end

    case (state_q)
      FILL: begin
        if (accept && !beat_null) begin
          if (complete && slot_free) begin
            ov_d       = 1'b1;
            od_d       = merged_data;
            ok_d       = merged_keep;
            ol_d       = s_tlast;
            asm_data_d = '0;
            asm_keep_d = '0;
            asm_last_d = 1'b0;
            wcnt_d     = 3'd0;
          end else begin
            asm_data_d = merged_data;
            asm_keep_d = merged_keep;
            wcnt_d     = merged_cnt;
            if (complete) begin
              asm_last_d = s_tlast;
              state_d    = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (slot_free) begin
          ov_d       = 1'b1;
          od_d       = asm_data_q;
          ok_d       = asm_keep_q;
          ol_d       = asm_last_q;
          asm_data_d = '0;
          asm_keep_d = '0;
          asm_last_d = 1'b0;
          wcnt_d     = 3'd0;
          state_d    = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    if (flush) begin
      state_d    = FILL;
      asm_data_d = '0;
      asm_keep_d = '0;
      asm_last_d = 1'b0;
      wcnt_d     = 3'd0;
      ov_d       = 1'b0;
      od_d       = '0;
      ok_d       = '0;
      ol_d       = 1'b0;
      blocks_d   = '0;
      packets_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FILL;
      alive_q    <= 1'b0;
      asm_data_q <= '0;
      asm_keep_q <= '0;
      asm_last_q <= 1'b0;
      wcnt_q     <= 3'd0;
      ov_q       <= 1'b0;
      od_q       <= '0;
      ok_q       <= '0;
      ol_q       <= 1'b0;
      blocks_q   <= '0;
      packets_q  <= '0;
    end else begin
      state_q    <= state_d;
      alive_q    <= 1'b1;
      asm_data_q <= asm_data_d;
      asm_keep_q <= asm_keep_d;
      asm_last_q <= asm_last_d;
      wcnt_q     <= wcnt_d;
      ov_q       <= ov_d;
      od_q       <= od_d;
      ok_q       <= ok_d;
      ol_q       <= ol_d;
      blocks_q   <= blocks_d;
      packets_q  <= packets_d;
    end
  end

  assign out_valid   = ov_q;
  assign out_data    = od_q;
  assign out_keep    = ok_q;
  assign out_last    = ol_q;
  assign blocks_out  = blocks_q;
  assign packets_out = packets_q;
  assign busy        = (wcnt_q != 3'd0) || (state_q == HOLD) || ov_q;

`ifdef AES_PACKER_KEEPCHK_EN
  logic kerr_q, kerr_d;
  logic keep_contig;

  // Legal keeps fill from byte 0 upward; anything short of a full word must end the packet.
  always_comb begin
    keep_contig = (s_tkeep == 4'h0) || (s_tkeep == 4'h1) || (s_tkeep == 4'h3) ||
                  (s_tkeep == 4'h7) || (s_tkeep == 4'hF);
    kerr_d = kerr_q;
    if (accept && (!keep_contig || ((s_tkeep != 4'hF) && !s_tlast))) kerr_d = 1'b1;
    if (flush) kerr_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) kerr_q <= 1'b0;
    else        kerr_q <= kerr_d;
  end

  assign keep_err = kerr_q;
`endif

endmodule

// File: tb/tb_aes_axis_block_packer.sv
// Bench for aes_axis_block_packer: vector table, hand sequences and a randomized run against a packing model.
module tb_aes_axis_block_packer;
  localparam int CNT_W = 32;

  logic             clk, rst_n, flush;
  logic             s_tvalid, s_tready, s_tlast;
  logic [31:0]      s_tdata;
  logic [3:0]       s_tkeep;
  logic             out_valid, out_ready, out_last, busy;
  logic [127:0]     out_data;
  logic [15:0]      out_keep;
  logic [CNT_W-1:0] blocks_out, packets_out;
`ifdef AES_PACKER_KEEPCHK_EN
  logic             keep_err;
`endif

  aes_axis_block_packer #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_keep(out_keep),
    .out_last(out_last), .blocks_out(blocks_out), .packets_out(packets_out),
`ifdef AES_PACKER_KEEPCHK_EN
    .keep_err(keep_err),
`endif
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  // Reference model: blocks built from the list of accepted words of a packet.
  typedef struct {logic [127:0] d; logic [15:0] k; logic l;} blk_t;
  blk_t        exp_q[$];
  blk_t        mb;
  logic [31:0] wd[$];
  logic [3:0]  wk[$];
  int          m_blocks, m_packets;

  task automatic model_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    blk_t b;
    if (k == 4'h0 && !l) return;
    if (k != 4'h0) begin
      wd.push_back(d);
      wk.push_back(k);
    end
    if (wd.size() == 4 || l) begin
      b.d = '0;
      b.k = '0;
      for (int i = 0; i < wd.size(); i++) begin
        b.d[32*i +: 32] = wd[i];
        b.k[4*i +: 4]   = wk[i];
      end
      b.l = l;
      exp_q.push_back(b);
      wd.delete();
      wk.delete();
    end
  endtask

  logic         prev_hold;
  logic [127:0] pd;
  logic [15:0]  pk;
  logic         pl;

  always @(negedge clk) begin
    if (!rst_n || flush) begin
      exp_q.delete();
      wd.delete();
      wk.delete();
      m_blocks  = 0;
      m_packets = 0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, pd);
        chk("hold_keep", out_keep, pk);
        chk("hold_last", out_last, pl);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected: got block %0h expected none", out_data);
        end else begin
          mb = exp_q.pop_front();
          chk("sb_data", out_data, mb.d);
          chk("sb_keep", out_keep, mb.k);
          chk("sb_last", out_last, mb.l);
        end
        m_blocks++;
        if (out_last) m_packets++;
      end
      if (s_tvalid && s_tready) model_beat(s_tdata, s_tkeep, s_tlast);
      prev_hold = out_valid && !out_ready;
      pd = out_data;
      pk = out_keep;
      pl = out_last;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [3:0] k, input logic l);
    int n;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tkeep  = k;
    s_tlast  = l;
    @(negedge clk);
    while (!s_tready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_tready) fail_now("send_wait");
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tkeep  = 4'h0;
    s_tlast  = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (busy || exp_q.size() != 0) fail_now(name);
  endtask

  typedef struct {
    int           nb;
    logic [127:0] din;
    logic [15:0]  keeps;
    logic         lastf;
    logic [127:0] ed;
    logic [15:0]  ek;
    logic         el;
  } vec_t;

  vec_t       vecs[6];
  logic [3:0] kchoice[8];
  logic       acc;

  initial begin
    vecs[0] = '{4, 128'h0F0E0D0C_0B0A0908_07060504_03020100, 16'hFFFF, 1'b1,
                128'h0F0E0D0C_0B0A0908_07060504_03020100, 16'hFFFF, 1'b1};
    vecs[1] = '{1, 128'h00000000_00000000_00000000_DEADBEEF, 16'h0000, 1'b1,
                128'h0, 16'h0000, 1'b1};
    vecs[2] = '{2, 128'h00000000_00000000_11223344_55667788, 16'h003F, 1'b1,
                128'h00000000_00000000_11223344_55667788, 16'h003F, 1'b1};
    vecs[3] = '{3, 128'h00000000_CAFEF00D_A5A5A5A5_5A5A5A5A, 16'h00FF, 1'b1,
                128'h00000000_00000000_A5A5A5A5_5A5A5A5A, 16'h00FF, 1'b1};
    vecs[4] = '{1, 128'h00000000_00000000_00000000_12ABCDEF, 16'h0007, 1'b1,
                128'h00000000_00000000_00000000_12ABCDEF, 16'h0007, 1'b1};
    vecs[5] = '{4, 128'hC3C3C3C3_96969696_3C3C3C3C_69696969, 16'hFFFF, 1'b0,
                128'hC3C3C3C3_96969696_3C3C3C3C_69696969, 16'hFFFF, 1'b0};
    kchoice = '{4'hF, 4'hF, 4'hF, 4'hF, 4'h1, 4'h3, 4'h7, 4'h0};

    rst_n = 1'b0; flush = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tkeep = '0; s_tlast = 1'b0;
    out_ready = 1'b1;
    #3;
    chk("rst_tready", s_tready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_blocks", blocks_out, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();
    @(negedge clk);
    chk("post_rst_tready", s_tready, 1);
`ifdef AES_PACKER_KEEPCHK_EN
    chk("rst_keep_err", keep_err, 0);
`endif
    tick();

    for (int r = 0; r < 6; r++) begin
      for (int b = 0; b < vecs[r].nb; b++)
        send(vecs[r].din[32*b +: 32], vecs[r].keeps[4*b +: 4], vecs[r].lastf && (b == vecs[r].nb - 1));
      @(negedge clk);
      chk($sformatf("tbl%0d_valid", r), out_valid, 1);
      chk($sformatf("tbl%0d_data", r), out_data, vecs[r].ed);
      chk($sformatf("tbl%0d_keep", r), out_keep, vecs[r].ek);
      chk($sformatf("tbl%0d_last", r), out_last, vecs[r].el);
      tick();
      @(negedge clk);
      chk($sformatf("tbl%0d_drop", r), out_valid, 0);
      tick();
    end
    @(negedge clk);
    chk("tbl_blocks", blocks_out, 6);
    chk("tbl_packets", packets_out, 5);
    tick();

    // Flush drops a partial block; a beat offered during flush is refused.
    send(32'hAAAA0000, 4'hF, 1'b0);
    send(32'hAAAA0001, 4'hF, 1'b0);
    @(negedge clk);
    chk("fl_busy_before", busy, 1);
    tick();
    flush = 1'b1; s_tvalid = 1'b1; s_tdata = 32'hBAD0BAD0; s_tkeep = 4'hF;
    @(negedge clk);
    chk("fl_tready", s_tready, 0);
    tick();
    flush = 1'b0; s_tvalid = 1'b0; s_tkeep = 4'h0;
    @(negedge clk);
    chk("fl_valid", out_valid, 0);
    chk("fl_busy", busy, 0);
    chk("fl_blocks", blocks_out, 0);
    chk("fl_packets", packets_out, 0);
    tick();
    for (int i = 0; i < 4; i++) send(32'hD0D0D000 + i, 4'hF, i == 3);
    @(negedge clk);
    chk("fl_next_data", out_data, 128'hD0D0D003_D0D0D002_D0D0D001_D0D0D000);
    chk("fl_next_last", out_last, 1);
    tick();

    // Six beats split into a full block and a half block.
    do_flush();
    for (int i = 0; i < 6; i++) send(32'h10000000 + i, 4'hF, i == 5);
    @(negedge clk);
    chk("six_keep", out_keep, 16'h00FF);
    chk("six_last", out_last, 1);
    chk("six_upper", out_data[127:64], 0);
    wait_idle("six_idle");
    chk("six_blocks", blocks_out, 2);
    chk("six_packets", packets_out, 1);
    tick();

    // Backpressure: second block fills behind the stalled first one, then input stalls.
    do_flush();
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(32'h20000000 + i, 4'hF, i == 7);
    @(negedge clk);
    chk("bp_tready", s_tready, 0);
    chk("bp_valid", out_valid, 1);
    chk("bp_data", out_data, 128'h20000003_20000002_20000001_20000000);
    chk("bp_busy", busy, 1);
    repeat (3) tick();
    @(negedge clk);
    chk("bp_tready_still", s_tready, 0);
    tick();
    out_ready = 1'b1;
    wait_idle("bp_idle");
    chk("bp_blocks", blocks_out, 2);
    chk("bp_packets", packets_out, 1);
    tick();

    // Null beat is swallowed and takes no lane.
    do_flush();
`ifdef AES_PACKER_KEEPCHK_EN
    @(negedge clk);
    chk("ke_clear", keep_err, 0);
    tick();
`endif
    send(32'h99999999, 4'h0, 1'b0);
    @(negedge clk);
    chk("null_valid", out_valid, 0);
    chk("null_busy", busy, 0);
`ifdef AES_PACKER_KEEPCHK_EN
    chk("ke_set", keep_err, 1);
`endif
    tick();
    send(32'h00000077, 4'hF, 1'b1);
    @(negedge clk);
    chk("null_next_data", out_data, 128'h77);
    chk("null_next_keep", out_keep, 16'h000F);
    wait_idle("null_idle");
    chk("null_blocks", blocks_out, 1);
    tick();

    // Asynchronous reset with a block pending and three words gathered.
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(32'h30000000 + i, 4'hF, i == 3);
    @(negedge clk);
    chk("ar_pre_valid", out_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid", out_valid, 0);
    chk("ar_data", out_data, 0);
    chk("ar_keep", out_keep, 0);
    chk("ar_last", out_last, 0);
    chk("ar_busy", busy, 0);
    chk("ar_blocks", blocks_out, 0);
    chk("ar_tready", s_tready, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) send(32'h40000000 + i, 4'hF, i == 3);
    @(negedge clk);
    chk("ar_next_data", out_data, 128'h40000003_40000002_40000001_40000000);
    chk("ar_next_keep", out_keep, 16'hFFFF);
    tick();

    // Randomized traffic with random backpressure and one mid-run flush.
    do_flush();
    acc = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!s_tvalid || acc) begin
        if ($urandom_range(0, 3) != 0) begin
          s_tvalid = 1'b1;
          s_tdata  = $urandom;
          s_tkeep  = kchoice[$urandom_range(0, 7)];
          s_tlast  = ($urandom_range(0, 4) == 0);
        end else begin
          s_tvalid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 2) != 0);
      flush = (i == 400);
      @(negedge clk);
      acc = s_tvalid && s_tready;
      tick();
    end
    flush = 1'b0;
    s_tvalid = 1'b0;
    out_ready = 1'b1;
    send(32'h0, 4'h0, 1'b1);
    wait_idle("rnd_idle");
    chk("rnd_blocks", blocks_out, m_blocks);
    chk("rnd_packets", packets_out, m_packets);
    chk("rnd_pending", wd.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
